// File: rtl/bsa_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package bsa_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
interface bit_serial_subtractor_if
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             diff_bit;
  logic             bit_valid;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a_in, b_in,
    input  busy, diff_bit, bit_valid, done, diff, borrow_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, diff_bit, bit_valid, done, diff, borrow_out
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the step borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial A-B: operands shift out LSB-first through one full subtractor,
// difference bits shift in MSB-side and are presented in parallel with done.
module bit_serial_subtractor
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  bit_serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               br, br_n;
  logic [WIDTH-1:0]   a_sh, a_sh_n;
  logic [WIDTH-1:0]   b_sh, b_sh_n;
  logic [WIDTH-1:0]   res, res_n;
  logic               busy_q, busy_n;
  logic               diff_bit_q, diff_bit_n;
  logic               bit_valid_q, bit_valid_n;
  logic               done_q, done_n;
  logic [WIDTH-1:0]   diff_q, diff_n;
  logic               borrow_q, borrow_n;

  logic               fs_d;
  logic               fs_bout;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      br          <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      res         <= '0;
      busy_q      <= 1'b0;
      diff_bit_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      br          <= br_n;
      a_sh        <= a_sh_n;
      b_sh        <= b_sh_n;
      res         <= res_n;
      busy_q      <= busy_n;
      diff_bit_q  <= diff_bit_n;
      bit_valid_q <= bit_valid_n;
      done_q      <= done_n;
      diff_q      <= diff_n;
      borrow_q    <= borrow_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    br_n        = br;
    a_sh_n      = a_sh;
    b_sh_n      = b_sh;
    res_n       = res;
    diff_bit_n  = diff_bit_q;
    bit_valid_n = 1'b0;
    done_n      = 1'b0;
    diff_n      = diff_q;
    borrow_n    = borrow_q;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_n  = bus.a_in;
          b_sh_n  = bus.b_in;
          br_n    = 1'b0;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_n      = {1'b0, a_sh[WIDTH-1:1]};
        b_sh_n      = {1'b0, b_sh[WIDTH-1:1]};
        res_n       = {fs_d, res[WIDTH-1:1]};
        br_n        = fs_bout;
        diff_bit_n  = fs_d;
        bit_valid_n = 1'b1;
        cnt_n       = cnt + CNT_W'(1);
        // Final bit step: publish the result so it is valid alongside done
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n  = ST_DONE;
          cnt_n    = '0;
          done_n   = 1'b1;
          diff_n   = res_n;
          borrow_n = fs_bout;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  assign bus.busy       = busy_q;
  assign bus.diff_bit   = diff_bit_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH=8).
module tb_bit_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bit_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done, collecting bit_valid-qualified serial bits LSB-first.
  task automatic wait_done(output int cyc, output logic [7:0] bits, output int nbits, output bit got);
    cyc = 0; nbits = 0; bits = '0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      cyc++;
      if (bus.bit_valid) begin
        if (nbits < 8) bits[nbits[2:0]] = bus.diff_bit;
        nbits++;
      end
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (bus.done) n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_diff, input logic exp_borrow, input string tag);
    int cyc, nbits;
    logic [7:0] bits;
    bit got;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(cyc, bits, nbits, got);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_nbits"}, 32'(nbits), 32'd8);
    check({tag, "_serial"}, 32'(bits), 32'(exp_diff));
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(exp_borrow));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_diff_held"}, 32'(bus.diff), 32'(exp_diff));
  endtask

  initial begin
    int cyc, nbits, n;
    logic [7:0] bits;
    bit got;
    int done_t[$];
    int busy_low;

    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    reset     = 1'b1;

    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("rst_diff_bit", 32'(bus.diff_bit), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow_out), 32'd0);
    #14;
    reset = 1'b0;
    tick();

    // Basic and boundary operations
    run_op(8'd123, 8'd32, 8'h5B, 1'b0, "op_123_32");
    run_op(8'd32, 8'd123, 8'hA5, 1'b1, "op_32_123");
    run_op(8'd0, 8'd1, 8'hFF, 1'b1, "op_0_1");
    run_op(8'd255, 8'd255, 8'h00, 1'b0, "op_255_255");
    run_op(8'd0, 8'd0, 8'h00, 1'b0, "op_0_0");

    // Start while busy is ignored
    bus.a_in = 8'd123; bus.b_in = 8'd32; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a_in = 8'd10; bus.b_in = 8'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(cyc, bits, nbits, got);
    check("busy_start_done_seen", 32'(got), 32'd1);
    check("busy_start_latency", 32'(cyc), 32'd5);
    check("busy_start_diff", 32'(bus.diff), 32'd91);
    count_dones(12, n);
    check("busy_start_no_extra_done", 32'(n), 32'd0);
    check("busy_start_idle", 32'(bus.busy), 32'd0);
    run_op(8'd10, 8'd3, 8'd7, 1'b0, "op_10_3");

    // Reset mid-SHIFT aborts and clears
    bus.a_in = 8'd123; bus.b_in = 8'd32; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("midrst_diff_bit", 32'(bus.diff_bit), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    tick();
    reset = 1'b0;
    count_dones(12, n);
    check("midrst_no_done", 32'(n), 32'd0);
    check("midrst_diff_still_0", 32'(bus.diff), 32'd0);
    run_op(8'd200, 8'd56, 8'd144, 1'b0, "op_200_56");

    // start held high: one operation every WIDTH+2 cycles
    bus.a_in = 8'd5; bus.b_in = 8'd9; bus.start = 1'b1;
    busy_low = 0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (bus.done) begin
        done_t.push_back(t);
        check("held_diff", 32'(bus.diff), 32'd252);
        check("held_borrow", 32'(bus.borrow_out), 32'd1);
      end
      if (done_t.size() > 0 && done_t.size() < 4 && !bus.busy) busy_low++;
    end
    bus.start = 1'b0;
    check("held_ndone", 32'(done_t.size()), 32'd4);
    if (done_t.size() == 4) begin
      check("held_first_done", 32'(done_t[0]), 32'd9);
      for (int k = 1; k < 4; k++)
        check("held_period", 32'(done_t[k] - done_t[k-1]), 32'd10);
    end
    check("held_busy_low_cycles", 32'(busy_low), 32'd3);
    wait_done(cyc, bits, nbits, got);
    check("held_tail_done_seen", 32'(got), 32'd1);
    check("held_tail_diff", 32'(bus.diff), 32'd252);
    tick();
    check("held_tail_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
